traffic_sched: RTL and testbench

TRAFFIC_SCHED -- requirements
Module: traffic_sched

---
 rtl/traffic_pkg.sv | 48 ++++
 rtl/traffic_sched_if.sv | 27 ++
 rtl/traffic_cfg_regs.sv | 47 ++++
 rtl/traffic_sched.sv | 160 ++++++++++++++++
 tb/tb_traffic_sched.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/traffic_pkg.sv
// Shared encodings for the two-direction traffic scheduler: lamps, phases,
// default phase durations and the duration register address map.
package traffic_pkg;

   localparam logic [3:0] LAMP_RED  = 4'b0001;
   localparam logic [3:0] LAMP_YEL  = 4'b0010;
   localparam logic [3:0] LAMP_GRN  = 4'b0100;
   localparam logic [3:0] LAMP_LEFT = 4'b1000;

   typedef enum logic [3:0] {
      ST_IDLE = 4'd0,
      ST_AG   = 4'd1,
      ST_AY1  = 4'd2,
      ST_AL   = 4'd3,
      ST_AY2  = 4'd4,
      ST_ACLR = 4'd5,
      ST_BG   = 4'd6,
      ST_BY1  = 4'd7,
      ST_BL   = 4'd8,
      ST_BY2  = 4'd9,
      ST_BCLR = 4'd10,
      ST_EMG  = 4'd11
   } state_e;

   localparam logic [2:0] ADDR_AG  = 3'd0;
   localparam logic [2:0] ADDR_AL  = 3'd1;
   localparam logic [2:0] ADDR_BG  = 3'd2;
   localparam logic [2:0] ADDR_BL  = 3'd3;
   localparam logic [2:0] ADDR_Y   = 3'd4;
   localparam logic [2:0] ADDR_CLR = 3'd5;

   localparam logic [7:0] DEF_AG  = 8'd40;
   localparam logic [7:0] DEF_AL  = 8'd20;
   localparam logic [7:0] DEF_BG  = 8'd25;
   localparam logic [7:0] DEF_BL  = 8'd10;
   localparam logic [7:0] DEF_Y   = 8'd5;
   localparam logic [7:0] DEF_CLR = 8'd2;

   typedef struct packed {
      logic [7:0] ag;
      logic [7:0] al;
      logic [7:0] bg;
      logic [7:0] bl;
      logic [7:0] y;
      logic [7:0] clr;
   } dur_t;

endpackage

// File: rtl/traffic_sched_if.sv
// Control, configuration and lamp/count signals of the traffic scheduler.
interface traffic_sched_if;
   import traffic_pkg::*;

   logic       tick;
   logic       en;
   logic       hold;
   logic       emg;
   logic       cfg_we;
   logic [2:0] cfg_addr;
   logic [7:0] cfg_data;
   logic [3:0] lampa;
   logic [3:0] lampb;
   logic [7:0] acount;
   logic [7:0] bcount;
   logic [3:0] phase;

   modport master (
      output tick, en, hold, emg, cfg_we, cfg_addr, cfg_data,
      input  lampa, lampb, acount, bcount, phase
   );

   modport slave (
      input  tick, en, hold, emg, cfg_we, cfg_addr, cfg_data,
      output lampa, lampb, acount, bcount, phase
   );
endinterface

// File: rtl/traffic_cfg_regs.sv
// Phase duration register file; zero writes are clamped to 1 except for the
// LEFT durations, where zero means "skip the LEFT phase".
module traffic_cfg_regs
   import traffic_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       we_i,
   input  logic [2:0] addr_i,
   input  logic [7:0] data_i,
   output dur_t       dur_o,
   output logic       skip_al_o,
   output logic       skip_bl_o
);

   dur_t       dur_q, dur_d;
   logic [7:0] data_clamped;

   always_comb begin
      data_clamped = (data_i == 8'd0) ? 8'd1 : data_i;
      dur_d        = dur_q;
      if (we_i) begin
         case (addr_i)
            ADDR_AG:  dur_d.ag  = data_clamped;
            ADDR_AL:  dur_d.al  = data_i;
            ADDR_BG:  dur_d.bg  = data_clamped;
            ADDR_BL:  dur_d.bl  = data_i;
            ADDR_Y:   dur_d.y   = data_clamped;
            ADDR_CLR: dur_d.clr = data_clamped;
            default:  dur_d     = dur_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dur_q <= '{ag: DEF_AG, al: DEF_AL, bg: DEF_BG, bl: DEF_BL, y: DEF_Y, clr: DEF_CLR};
      end else begin
         dur_q <= dur_d;
      end
   end

   assign dur_o     = dur_q;
   assign skip_al_o = (dur_q.al == 8'd0);
   assign skip_bl_o = (dur_q.bl == 8'd0);

endmodule

// File: rtl/traffic_sched.sv
// Two-direction traffic light phase sequencer with emergency preemption,
// hold, and per-direction countdowns to the next lamp change.
module traffic_sched
   import traffic_pkg::*;
(
   input  logic           clk,
   input  logic           rst_n,
   traffic_sched_if.slave bus
);

   dur_t        dur;
   logic        skip_al, skip_bl;
   state_e      state_q, state_d, nxt_s;
   logic [7:0]  remain_q, remain_d;
   logic [3:0]  lampa_q, lampb_q;
   logic        run_tick, phase_end;
   logic [10:0] a_sum, b_sum, a_tail, b_tail, rem_w;

   traffic_cfg_regs u_cfg (
      .clk       (clk),
      .rst_n     (rst_n),
      .we_i      (bus.cfg_we),
      .addr_i    (bus.cfg_addr),
      .data_i    (bus.cfg_data),
      .dur_o     (dur),
      .skip_al_o (skip_al),
      .skip_bl_o (skip_bl)
   );

   function automatic state_e next_phase(state_e s, logic sk_al, logic sk_bl);
      case (s)
         ST_AG:   return ST_AY1;
         ST_AY1:  return sk_al ? ST_ACLR : ST_AL;
         ST_AL:   return ST_AY2;
         ST_AY2:  return ST_ACLR;
         ST_ACLR: return ST_BG;
         ST_BG:   return ST_BY1;
         ST_BY1:  return sk_bl ? ST_BCLR : ST_BL;
         ST_BL:   return ST_BY2;
         ST_BY2:  return ST_BCLR;
         ST_BCLR: return ST_AG;
         default: return ST_IDLE;
      endcase
   endfunction

   function automatic logic [7:0] phase_len(state_e s, dur_t d);
      case (s)
         ST_AG:                          return d.ag;
         ST_AL:                          return d.al;
         ST_BG:                          return d.bg;
         ST_BL:                          return d.bl;
         ST_AY1, ST_AY2, ST_BY1, ST_BY2: return d.y;
         ST_ACLR, ST_BCLR:               return d.clr;
         default:                        return 8'd0;
      endcase
   endfunction

   function automatic logic [3:0] lamp_of(state_e s, logic dir_b);
      if (s == (dir_b ? ST_BG : ST_AG)) return LAMP_GRN;
      if (s == (dir_b ? ST_BL : ST_AL)) return LAMP_LEFT;
      if (s == (dir_b ? ST_BY1 : ST_AY1) || s == (dir_b ? ST_BY2 : ST_AY2)) return LAMP_YEL;
      return LAMP_RED;
   endfunction

   function automatic logic [7:0] sat8(logic [10:0] v);
      return (v > 11'd255) ? 8'd255 : v[7:0];
   endfunction

   // Emergency overrides hold so preemption always makes progress.
   assign run_tick  = bus.tick && !(bus.hold && !bus.emg);
   assign phase_end = run_tick && (remain_q <= 8'd1);
   assign nxt_s     = next_phase(state_q, skip_al, skip_bl);

   always_comb begin
      state_d  = state_q;
      remain_d = remain_q;
      if (!bus.en) begin
         state_d  = ST_IDLE;
         remain_d = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d  = ST_AG;
               remain_d = dur.ag;
            end
            ST_EMG: begin
               if (!bus.emg) begin
                  state_d  = ST_ACLR;
                  remain_d = dur.clr;
               end
            end
            default: begin
               if (bus.emg && (state_q inside {ST_AG, ST_AL, ST_BG, ST_BL})) begin
                  state_d  = nxt_s;
                  remain_d = dur.y;
               end else if (phase_end) begin
                  if (bus.emg) begin
                     state_d  = ST_EMG;
                     remain_d = '0;
                  end else begin
                     state_d  = nxt_s;
                     remain_d = phase_len(nxt_s, dur);
                  end
               end else if (run_tick) begin
                  remain_d = remain_q - 8'd1;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         remain_q <= '0;
         lampa_q  <= LAMP_RED;
         lampb_q  <= LAMP_RED;
      end else begin
         state_q  <= state_d;
         remain_q <= remain_d;
         lampa_q  <= lamp_of(state_d, 1'b0);
         lampb_q  <= lamp_of(state_d, 1'b1);
      end
   end

   // Red direction waits for the rest of the other direction's sequence.
   always_comb begin
      rem_w  = 11'(remain_q);
      a_tail = skip_al ? 11'd0 : (11'(dur.al) + 11'(dur.y));
      b_tail = skip_bl ? 11'd0 : (11'(dur.bl) + 11'(dur.y));
      a_sum  = '0;
      b_sum  = '0;
      case (state_q)
         ST_AG:   begin a_sum = rem_w; b_sum = rem_w + 11'(dur.y) + a_tail + 11'(dur.clr); end
         ST_AY1:  begin a_sum = rem_w; b_sum = rem_w + a_tail + 11'(dur.clr); end
         ST_AL:   begin a_sum = rem_w; b_sum = rem_w + 11'(dur.y) + 11'(dur.clr); end
         ST_AY2:  begin a_sum = rem_w; b_sum = rem_w + 11'(dur.clr); end
         ST_ACLR: begin
            b_sum = rem_w;
            a_sum = rem_w + 11'(dur.bg) + 11'(dur.y) + b_tail + 11'(dur.clr);
         end
         ST_BG:   begin b_sum = rem_w; a_sum = rem_w + 11'(dur.y) + b_tail + 11'(dur.clr); end
         ST_BY1:  begin b_sum = rem_w; a_sum = rem_w + b_tail + 11'(dur.clr); end
         ST_BL:   begin b_sum = rem_w; a_sum = rem_w + 11'(dur.y) + 11'(dur.clr); end
         ST_BY2:  begin b_sum = rem_w; a_sum = rem_w + 11'(dur.clr); end
         ST_BCLR: begin
            a_sum = rem_w;
            b_sum = rem_w + 11'(dur.ag) + 11'(dur.y) + a_tail + 11'(dur.clr);
         end
         default: begin a_sum = '0; b_sum = '0; end
      endcase
   end

   assign bus.lampa  = lampa_q;
   assign bus.lampb  = lampb_q;
   assign bus.acount = sat8(a_sum);
   assign bus.bcount = sat8(b_sum);
   assign bus.phase  = state_q;

endmodule

// File: tb/tb_traffic_sched.sv
// Directed and randomized bench for traffic_sched against a phase-walking
// reference model of the signal plan.
module tb_traffic_sched;

   localparam int P_IDLE = 0, P_AG = 1, P_AY1 = 2, P_AL = 3, P_AY2 = 4, P_ACLR = 5;
   localparam int P_BG = 6, P_BY1 = 7, P_BL = 8, P_BY2 = 9, P_BCLR = 10, P_EMG = 11;
   localparam int RED = 1, YEL = 2, GRN = 4, LEFT = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int   checks = 0;
   int   failures = 0;

   int m_dur[6];
   int m_p;
   int m_rem;

   traffic_sched_if bus_if ();

   traffic_sched dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Model: phases follow the signal plan in cycle order; durations by name.
   function automatic int succ(int p);
      return (p == P_BCLR) ? P_AG : p + 1;
   endfunction

   function automatic int m_next(int p);
      int n = succ(p);
      if ((n == P_AL && m_dur[1] == 0) || (n == P_BL && m_dur[3] == 0)) n = succ(succ(n));
      return n;
   endfunction

   function automatic int m_len(int p);
      case (p)
         P_AG: return m_dur[0];
         P_AL: return m_dur[1];
         P_BG: return m_dur[2];
         P_BL: return m_dur[3];
         P_AY1, P_AY2, P_BY1, P_BY2: return m_dur[4];
         P_ACLR, P_BCLR: return m_dur[5];
         default: return 0;
      endcase
   endfunction

   function automatic int m_lamp(bit dir_b, int p);
      int q = p - (dir_b ? 5 : 0);
      if (q == 1) return GRN;
      if (q == 2 || q == 4) return YEL;
      if (q == 3) return LEFT;
      return RED;
   endfunction

   function automatic int m_count(bit dir_b);
      int s, n, guard;
      int green = dir_b ? P_BG : P_AG;
      if (m_p == P_IDLE || m_p == P_EMG) return 0;
      if (m_lamp(dir_b, m_p) != RED) return m_rem;
      s = m_rem;
      n = m_next(m_p);
      guard = 0;
      while (n != green && guard < 12) begin
         s += m_len(n);
         n = m_next(n);
         guard++;
      end
      return (s > 255) ? 255 : s;
   endfunction

   task automatic m_reset();
      m_p = P_IDLE;
      m_rem = 0;
      m_dur = '{40, 20, 25, 10, 5, 2};
   endtask

   task automatic m_step(input bit en_v, input bit emg_v, input bit hold_v, input bit tk,
                         input bit we, input int addr, input int data);
      bit go = (m_lamp(0, m_p) inside {GRN, LEFT}) || (m_lamp(1, m_p) inside {GRN, LEFT});
      if (!en_v) begin
         m_p = P_IDLE; m_rem = 0;
      end else if (m_p == P_IDLE) begin
         m_p = P_AG; m_rem = m_len(P_AG);
      end else if (m_p == P_EMG) begin
         if (!emg_v) begin m_p = P_ACLR; m_rem = m_len(P_ACLR); end
      end else if (emg_v && go) begin
         m_p = m_next(m_p); m_rem = m_dur[4];
      end else if (tk && (!hold_v || emg_v)) begin
         if (m_rem <= 1) begin
            if (emg_v) begin m_p = P_EMG; m_rem = 0; end
            else begin m_p = m_next(m_p); m_rem = m_len(m_p); end
         end else begin
            m_rem--;
         end
      end
      if (we && addr < 6) m_dur[addr] = (data == 0 && addr != 1 && addr != 3) ? 1 : data;
   endtask

   task automatic compare_all();
      chk("phase",  bus_if.phase,  m_p);
      chk("lampa",  bus_if.lampa,  m_lamp(0, m_p));
      chk("lampb",  bus_if.lampb,  m_lamp(1, m_p));
      chk("acount", bus_if.acount, m_count(0));
      chk("bcount", bus_if.bcount, m_count(1));
   endtask

   task automatic cyc(input bit tk);
      bus_if.tick = tk;
      @(posedge clk);
      m_step(bus_if.en, bus_if.emg, bus_if.hold, tk, bus_if.cfg_we, bus_if.cfg_addr, bus_if.cfg_data);
      #1;
      compare_all();
      bus_if.tick = 1'b0;
      bus_if.cfg_we = 1'b0;
   endtask

   task automatic cfg_write(input int addr, input int data);
      bus_if.cfg_we = 1'b1;
      bus_if.cfg_addr = 3'(addr);
      bus_if.cfg_data = 8'(data);
      cyc(1'b0);
   endtask

   task automatic run_until(input string tag, input int target);
      for (int i = 0; i < 400 && bus_if.phase != 4'(target); i++) cyc(1'b1);
      chk(tag, bus_if.phase, target);
   endtask

   initial begin
      int after_ay1, prev_ph;
      bit seen_left;
      bus_if.tick = 0; bus_if.en = 0; bus_if.hold = 0; bus_if.emg = 0;
      bus_if.cfg_we = 0; bus_if.cfg_addr = 0; bus_if.cfg_data = 0;
      m_reset();
      #1 rst_n = 1'b0;
      #2;
      chk("rst_phase", bus_if.phase, P_IDLE);
      chk("rst_lampa", bus_if.lampa, RED);
      chk("rst_lampb", bus_if.lampb, RED);
      chk("rst_acount", bus_if.acount, 0);
      chk("rst_bcount", bus_if.bcount, 0);
      @(posedge clk); #1 rst_n = 1'b1;
      cyc(0); cyc(0);

      // Default run
      bus_if.en = 1'b1;
      cyc(0);
      chk("def_phase", bus_if.phase, P_AG);
      chk("def_acount", bus_if.acount, 40);
      chk("def_bcount", bus_if.bcount, 72);
      for (int i = 0; i < 40; i++) cyc(1);
      chk("def_ay1", bus_if.phase, P_AY1);
      chk("def_ay1_acount", bus_if.acount, 5);

      // LEFT skip
      run_until("skip_reach_ag", P_AG);
      cfg_write(1, 0);
      chk("skip_bcount", bus_if.bcount, 47);
      seen_left = 0; after_ay1 = -1; prev_ph = P_AG;
      for (int i = 0; i < 300 && bus_if.phase != 4'(P_BG); i++) begin
         cyc(1);
         if (bus_if.lampa == 4'(LEFT) || bus_if.phase == 4'(P_AL)) seen_left = 1;
         if (prev_ph == P_AY1 && bus_if.phase != 4'(P_AY1) && after_ay1 < 0) after_ay1 = bus_if.phase;
         prev_ph = bus_if.phase;
      end
      chk("skip_reach_bg", bus_if.phase, P_BG);
      chk("skip_no_left", seen_left, 0);
      chk("skip_ay1_next", after_ay1, P_ACLR);
      cfg_write(1, 20);

      // Yellow clamp
      cfg_write(4, 0);
      run_until("clamp_reach_ay1", P_AY1);
      chk("clamp_ay1_cnt", bus_if.acount, 1);
      cyc(1);
      chk("clamp_ay1_len", bus_if.phase, P_AL);
      run_until("clamp_reach_by1", P_BY1);
      chk("clamp_by1_cnt", bus_if.bcount, 1);
      cyc(1);
      chk("clamp_by1_len", bus_if.phase, P_BL);
      cfg_write(4, 5);

      // Emergency from BG
      run_until("emg_reach_bg", P_BG);
      for (int i = 0; i < 13; i++) cyc(1);
      chk("emg_bg_rem", bus_if.bcount, 12);
      bus_if.emg = 1'b1;
      cyc(0);
      chk("emg_by1", bus_if.phase, P_BY1);
      chk("emg_by1_rem", bus_if.bcount, 5);
      for (int i = 0; i < 4; i++) cyc(1);
      chk("emg_still_by1", bus_if.phase, P_BY1);
      cyc(1);
      chk("emg_enter", bus_if.phase, P_EMG);
      chk("emg_lampb", bus_if.lampb, RED);
      chk("emg_bcount", bus_if.bcount, 0);
      bus_if.hold = 1'b1;
      for (int i = 0; i < 3; i++) cyc(1);
      chk("emg_stay", bus_if.phase, P_EMG);
      bus_if.hold = 1'b0;
      bus_if.emg = 1'b0;
      cyc(0);
      chk("emg_aclr", bus_if.phase, P_ACLR);
      chk("emg_aclr_rem", bus_if.bcount, 2);
      cyc(1); cyc(1);
      chk("emg_resume_bg", bus_if.phase, P_BG);

      // Hold during AL
      run_until("hold_reach_al", P_AL);
      for (int i = 0; i < 13; i++) cyc(1);
      chk("hold_al_rem", bus_if.acount, 7);
      bus_if.hold = 1'b1;
      for (int i = 0; i < 10; i++) cyc(1);
      chk("hold_frozen", bus_if.acount, 7);
      chk("hold_phase", bus_if.phase, P_AL);
      bus_if.hold = 1'b0;
      cyc(1);
      chk("hold_resume", bus_if.acount, 6);

      // Reset mid-BY2
      run_until("rst_reach_by2", P_BY2);
      cyc(1);
      rst_n = 1'b0;
      #2;
      m_reset();
      chk("rst_mid_phase", bus_if.phase, P_IDLE);
      chk("rst_mid_lampa", bus_if.lampa, RED);
      chk("rst_mid_lampb", bus_if.lampb, RED);
      chk("rst_mid_bcount", bus_if.bcount, 0);
      @(posedge clk); #1 rst_n = 1'b1;
      cyc(0);
      chk("rst_restart", bus_if.phase, P_AG);
      chk("rst_restart_cnt", bus_if.acount, 40);

      // Randomized traffic
      for (int i = 0; i < 4000; i++) begin
         bus_if.en = ($urandom_range(0, 149) != 0);
         bus_if.hold = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 59) == 0) bus_if.emg = ~bus_if.emg;
         if ($urandom_range(0, 24) == 0) begin
            bus_if.cfg_we = 1'b1;
            bus_if.cfg_addr = 3'($urandom_range(0, 7));
            bus_if.cfg_data = 8'($urandom_range(0, 9));
         end
         cyc(1'($urandom_range(0, 1)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
